// File: rtl/ddr3_avl_arbiter.sv
// ddr3_avl_arbiter: round-robin N-master arbiter onto one DDR3 Avalon-MM port with read credits and tag routing.
// Optional ARB_STATS_EN enables saturating read/write beat counters.
module ddr3_avl_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_W      = 26,
    parameter int DATA_W      = 128,
    parameter int SIZE_W      = 3,
    parameter int TAG_DEPTH   = 4,
    parameter int CREDIT_W    = 10,
    parameter int CREDIT_MAX  = 412
) (
    input  logic                          ddr3_clk,
    input  logic                          ddr3_reset_n,
    input  logic [NUM_MASTERS-1:0]        m_read_req,
    input  logic [NUM_MASTERS-1:0]        m_write_req,
    input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
    input  logic [NUM_MASTERS*SIZE_W-1:0] m_size,
    input  logic [NUM_MASTERS*DATA_W-1:0] m_wr_data,
    output logic [NUM_MASTERS-1:0]        m_ready,
    output logic [NUM_MASTERS-1:0]        m_rd_valid,
    output logic [DATA_W-1:0]             rd_data,
    input  logic [NUM_MASTERS-1:0]        credit_return,
    input  logic                          ddr3_avl_ready,
    output logic                          ddr3_avl_burstbegin,
    output logic [SIZE_W-1:0]             ddr3_avl_size,
    output logic                          ddr3_avl_read_req,
    output logic                          ddr3_avl_write_req,
    output logic [ADDR_W-1:0]             ddr3_avl_addr,
    output logic [DATA_W-1:0]             ddr3_avl_wr_data,
    input  logic                          ddr3_avl_read_data_valid,
    input  logic [DATA_W-1:0]             ddr3_avl_read_data,
    output logic                          err_unexp_rd,
    output logic [31:0]                   stat_rd_beats,
    output logic [31:0]                   stat_wr_beats
);
    localparam int MW  = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int TD  = 1 << TAG_DEPTH;
    localparam int CW1 = CREDIT_W + 1;

    typedef enum logic [1:0] {IDLE, GRANT_RD, GRANT_WR} state_t;

    state_t              r_state, w_state_nx;
    logic [MW-1:0]       r_gnt, w_gnt_nx, r_rr, w_rr_nx, w_pick, w_rr_inc;
    logic [SIZE_W-1:0]   r_size, w_size_nx, r_beats, w_beats_nx;
    logic                r_first, w_first_nx;
    logic                w_found, w_pick_rd, w_acc, w_push, w_pop, w_ret;
    logic [NUM_MASTERS-1:0] w_rd_elig;
    logic [CREDIT_W-1:0] r_credit [NUM_MASTERS];
    logic [CREDIT_W-1:0] w_sum [NUM_MASTERS];
    logic [CREDIT_W-1:0] w_credit_nx [NUM_MASTERS];
    logic [MW-1:0]       r_tag_m [TD];
    logic [SIZE_W-1:0]   r_tag_sz [TD];
    logic [TAG_DEPTH:0]  r_wp, r_rp;
    logic [SIZE_W-1:0]   r_head_cnt;
    logic                w_tag_full, w_tag_empty;
    logic [NUM_MASTERS-1:0] r_rd_valid;
    logic [DATA_W-1:0]   r_rd_data;
    logic                r_err;

    assign w_tag_empty = (r_wp == r_rp);
    assign w_tag_full  = (r_wp[TAG_DEPTH] != r_rp[TAG_DEPTH]) &&
                         (r_wp[TAG_DEPTH-1:0] == r_rp[TAG_DEPTH-1:0]);

    // A read is only eligible if its whole burst fits in the master's remaining credit
    always_comb begin
        for (int i = 0; i < NUM_MASTERS; i++)
            w_rd_elig[i] = m_read_req[i] && !w_tag_full &&
                ({1'b0, r_credit[i]} + CW1'(m_size[i*SIZE_W +: SIZE_W]) <= CW1'(CREDIT_MAX));
    end

    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int k = 0; k < NUM_MASTERS; k++)
            if (!w_found && (w_rd_elig[(int'(r_rr) + k) % NUM_MASTERS] ||
                             m_write_req[(int'(r_rr) + k) % NUM_MASTERS])) begin
                w_found = 1'b1;
                w_pick  = MW'((int'(r_rr) + k) % NUM_MASTERS);
            end
        w_pick_rd = w_rd_elig[w_pick];
    end

    assign ddr3_avl_read_req   = (r_state == GRANT_RD);
    assign ddr3_avl_write_req  = (r_state == GRANT_WR) && m_write_req[r_gnt];
    assign ddr3_avl_burstbegin = ddr3_avl_read_req || (ddr3_avl_write_req && r_first);
    assign ddr3_avl_size       = (r_state == IDLE) ? '0 : r_size;
    assign ddr3_avl_addr       = (r_state == IDLE) ? '0 : m_addr[r_gnt*ADDR_W +: ADDR_W];
    assign ddr3_avl_wr_data    = (r_state == GRANT_WR) ? m_wr_data[r_gnt*DATA_W +: DATA_W] : '0;
    assign w_acc               = ddr3_avl_ready && (ddr3_avl_read_req || ddr3_avl_write_req);
    assign w_push              = w_acc && ddr3_avl_read_req;
    assign m_ready             = w_acc ? (NUM_MASTERS'(1) << r_gnt) : '0;
    assign w_rr_inc            = (r_gnt == MW'(NUM_MASTERS - 1)) ? '0 : r_gnt + 1'b1;

    always_comb begin
        w_state_nx = r_state;
        w_gnt_nx   = r_gnt;
        w_rr_nx    = r_rr;
        w_size_nx  = r_size;
        w_beats_nx = r_beats;
        w_first_nx = r_first;
        case (r_state)
            IDLE: if (w_found) begin
                w_state_nx = w_pick_rd ? GRANT_RD : GRANT_WR;
                w_gnt_nx   = w_pick;
                w_size_nx  = m_size[w_pick*SIZE_W +: SIZE_W];
                w_beats_nx = m_size[w_pick*SIZE_W +: SIZE_W];
                w_first_nx = 1'b1;
            end
            GRANT_RD: if (ddr3_avl_ready) begin
                w_state_nx = IDLE;
                w_rr_nx    = w_rr_inc;
            end
            GRANT_WR: if (w_acc) begin
                w_beats_nx = r_beats - 1'b1;
                w_first_nx = 1'b0;
                if (r_beats == SIZE_W'(1)) begin
                    w_state_nx = IDLE;
                    w_rr_nx    = w_rr_inc;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge ddr3_clk or negedge ddr3_reset_n) begin
        if (!ddr3_reset_n) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_rr    <= '0;
            r_size  <= '0;
            r_beats <= '0;
            r_first <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_gnt   <= w_gnt_nx;
            r_rr    <= w_rr_nx;
            r_size  <= w_size_nx;
            r_beats <= w_beats_nx;
            r_first <= w_first_nx;
        end
    end

    // Reserve on command accept and release on consumption net out in one update; release at zero is dropped
    always_comb begin
        for (int i = 0; i < NUM_MASTERS; i++) begin
            w_sum[i]       = r_credit[i] + ((w_push && r_gnt == MW'(i)) ? CREDIT_W'(r_size) : '0);
            w_credit_nx[i] = (credit_return[i] && w_sum[i] != '0) ? w_sum[i] - 1'b1 : w_sum[i];
        end
    end

    always_ff @(posedge ddr3_clk or negedge ddr3_reset_n) begin
        if (!ddr3_reset_n)
            for (int i = 0; i < NUM_MASTERS; i++) r_credit[i] <= '0;
        else
            for (int i = 0; i < NUM_MASTERS; i++) r_credit[i] <= w_credit_nx[i];
    end

    always_ff @(posedge ddr3_clk) begin
        if (w_push) begin
            r_tag_m[r_wp[TAG_DEPTH-1:0]]  <= r_gnt;
            r_tag_sz[r_wp[TAG_DEPTH-1:0]] <= r_size;
        end
    end

    assign w_ret = ddr3_avl_read_data_valid && !w_tag_empty;
    assign w_pop = w_ret && (r_head_cnt + 1'b1 == r_tag_sz[r_rp[TAG_DEPTH-1:0]]);

    always_ff @(posedge ddr3_clk or negedge ddr3_reset_n) begin
        if (!ddr3_reset_n) begin
            r_wp       <= '0;
            r_rp       <= '0;
            r_head_cnt <= '0;
            r_rd_valid <= '0;
            r_rd_data  <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop) r_rp <= r_rp + 1'b1;
            if (w_ret) r_head_cnt <= w_pop ? '0 : r_head_cnt + 1'b1;
            r_rd_valid <= w_ret ? (NUM_MASTERS'(1) << r_tag_m[r_rp[TAG_DEPTH-1:0]]) : '0;
            if (w_ret) r_rd_data <= ddr3_avl_read_data;
            if (ddr3_avl_read_data_valid && w_tag_empty) r_err <= 1'b1;
        end
    end

    assign m_rd_valid   = r_rd_valid;
    assign rd_data      = r_rd_data;
    assign err_unexp_rd = r_err;

`ifdef ARB_STATS_EN
    logic [31:0] r_stat_rd, r_stat_wr;

    always_ff @(posedge ddr3_clk or negedge ddr3_reset_n) begin
        if (!ddr3_reset_n) begin
            r_stat_rd <= '0;
            r_stat_wr <= '0;
        end else begin
            if (w_ret && r_stat_rd != '1) r_stat_rd <= r_stat_rd + 1'b1;
            if (w_acc && ddr3_avl_write_req && r_stat_wr != '1) r_stat_wr <= r_stat_wr + 1'b1;
        end
    end

    assign stat_rd_beats = r_stat_rd;
    assign stat_wr_beats = r_stat_wr;
`else
    assign stat_rd_beats = '0;
    assign stat_wr_beats = '0;
`endif

endmodule
